// File: rtl/rv_ctrl_pkg.sv
// Shared control definitions: RV32I base opcodes, sequencer state and fault encodings.
package rv_ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      FAULT_NONE     = 2'b00,
      FAULT_ILLEGAL  = 2'b01,
      FAULT_TIMEOUT  = 2'b10,
      FAULT_MISALIGN = 2'b11
   } fault_e;

   function automatic logic is_legal_opcode(input logic [6:0] op);
      logic legal;
      legal = 1'b0;
      case (op)
         OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
         OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
         default:                           legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/fetch_seq_ctrl.sv
// Multi-cycle fetch/execute sequencer: owns the PC, handshakes with instruction memory,
// presents one instruction at a time and halts on illegal opcode, fetch timeout or bad target.
module fetch_seq_ctrl
   import rv_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter int unsigned FETCH_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic [31:0] pc,
   output logic        inst_valid,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic        halted,
   output logic [1:0]  fault_code,
   output logic [31:0] fault_pc,
   output logic [31:0] instret
);

   localparam int unsigned CNT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((FETCH_TIMEOUT == 0) ? 0 : FETCH_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      inst_q, inst_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      instret_q, instret_d;
   fault_e           fault_q, fault_d;
   logic [31:0]      fault_pc_q, fault_pc_d;

   logic             legal;
   logic [31:0]      next_pc;

   assign legal = is_legal_opcode(inst_q[6:0]);

   // Bit 0 of a redirect target is always dropped; a set bit 1 is what faults.
   assign next_pc = br_taken ? (br_target & ~32'h1) : (pc_q + 32'd4);

   // NOTE: every register written in this block gets its hold value first, so no
   // branch of the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      inst_d     = inst_q;
      cnt_d      = cnt_q;
      instret_d  = instret_q;
      fault_d    = fault_q;
      fault_pc_d = fault_pc_q;

      case (state_q)
         ST_IDLE: begin
            state_d = ST_FETCH;
            cnt_d   = '0;
         end

         ST_FETCH: begin
            if (imem_ack) begin
               inst_d  = imem_rdata;
               state_d = ST_EXEC;
            end else if ((FETCH_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
               state_d    = ST_HALT;
               fault_d    = FAULT_TIMEOUT;
               fault_pc_d = pc_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_EXEC: begin
            if (!legal) begin
               state_d    = ST_HALT;
               fault_d    = FAULT_ILLEGAL;
               fault_pc_d = pc_q;
            end else if (!stall) begin
               instret_d = instret_q + 32'd1;
               if (next_pc[1]) begin
                  state_d    = ST_HALT;
                  fault_d    = FAULT_MISALIGN;
                  fault_pc_d = pc_q;
               end else begin
                  pc_d    = next_pc;
                  state_d = ST_FETCH;
                  cnt_d   = '0;
               end
            end
         end

         ST_HALT: begin
            state_d = ST_HALT;
         end

         default: begin
            state_d = ST_HALT;
         end
      endcase
   end

   // NOTE: state registers take non-blocking assignments so every flop samples
   // the values from before this edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC;
         inst_q     <= '0;
         cnt_q      <= '0;
         instret_q  <= '0;
         fault_q    <= FAULT_NONE;
         fault_pc_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inst_q     <= inst_d;
         cnt_q      <= cnt_d;
         instret_q  <= instret_d;
         fault_q    <= fault_d;
         fault_pc_q <= fault_pc_d;
      end
   end

   // Outputs decode from state alone, so a dropped request vanishes the cycle after rst.
   assign imem_req   = (state_q == ST_FETCH);
   assign imem_addr  = (state_q == ST_FETCH) ? pc_q : 32'h0;
   assign inst       = (state_q == ST_EXEC) ? inst_q : 32'h0;
   assign inst_valid = (state_q == ST_EXEC) && legal;
   assign halted     = (state_q == ST_HALT);
   assign pc         = pc_q;
   assign fault_code = fault_q;
   assign fault_pc   = fault_pc_q;
   assign instret    = instret_q;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Bench for fetch_seq_ctrl: a directed vector table, hand-written corner sequences and
// randomized programs checked against an instruction-level reference model.
module tb_fetch_seq_ctrl;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        inst_valid;
   logic        stall;
   logic        br_taken;
   logic [31:0] br_target;
   logic        halted;
   logic [1:0]  fault_code;
   logic [31:0] fault_pc;
   logic [31:0] instret;

   int n_total = 0;
   int n_bad   = 0;

   // instruction-level reference model state
   logic [31:0] m_pc;
   logic [31:0] m_ret;
   logic        m_halt;
   logic [1:0]  m_fault;
   logic [31:0] m_fpc;

   typedef struct {
      logic [31:0] rst, ack, rdata, stall, br, tgt;
      logic [31:0] req, addr, inst, iv, pc, halt, fault, fpc, ret;
   } vec_t;

   vec_t vecs[14];

   fetch_seq_ctrl #(.RESET_PC(32'h0), .FETCH_TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .inst       (inst),
      .pc         (pc),
      .inst_valid (inst_valid),
      .stall      (stall),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .halted     (halted),
      .fault_code (fault_code),
      .fault_pc   (fault_pc),
      .instret    (instret)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", n_total, n_bad);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // inputs change and outputs are sampled on the falling edge
   task automatic step();
      @(negedge clk);
   endtask

   function automatic bit tb_legal(input logic [31:0] w);
      case (w[6:0])
         7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
         7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic check_status(input string tag);
      check({tag, ".halted"},  32'(halted), 32'(m_halt));
      check({tag, ".fault"},   32'(fault_code), 32'(m_fault));
      check({tag, ".fpc"},     fault_pc, m_fpc);
      check({tag, ".instret"}, instret, m_ret);
      check({tag, ".pc"},      pc, m_pc);
      if (m_halt) begin
         check({tag, ".req"},  32'(imem_req), 32'd0);
         check({tag, ".iv"},   32'(inst_valid), 32'd0);
         check({tag, ".inst"}, inst, 32'h0);
      end else begin
         check({tag, ".req"},  32'(imem_req), 32'd1);
         check({tag, ".addr"}, imem_addr, m_pc);
      end
   endtask

   // Leaves the DUT in its first FETCH cycle with the model reset to match.
   task automatic do_reset();
      rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
      stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
      step();
      check("rst.req",     32'(imem_req), 32'd0);
      check("rst.addr",    imem_addr, 32'h0);
      check("rst.iv",      32'(inst_valid), 32'd0);
      check("rst.inst",    inst, 32'h0);
      check("rst.pc",      pc, 32'h0);
      check("rst.halted",  32'(halted), 32'd0);
      check("rst.fault",   32'(fault_code), 32'd0);
      check("rst.instret", instret, 32'h0);
      rst = 1'b0;
      step();
      m_pc = 32'h0; m_ret = 32'h0; m_halt = 1'b0; m_fault = 2'b00; m_fpc = 32'h0;
   endtask

   // One instruction: fetch with 'delay' ack-wait cycles, 'nstall' stalled cycles, then commit.
   task automatic exec_insn(input logic [31:0] word, input int delay, input int nstall,
                            input logic br, input logic [31:0] tgt);
      logic [31:0] npc;
      bit          legal;
      if (m_halt) return;
      legal = tb_legal(word);
      for (int k = 0; k <= delay && k < TIMEOUT; k++) begin
         check("fetch.req",  32'(imem_req), 32'd1);
         check("fetch.addr", imem_addr, m_pc);
         imem_ack   = (k == delay);
         imem_rdata = (k == delay) ? word : $urandom;
         step();
      end
      imem_ack = 1'b0;
      if (delay >= TIMEOUT) begin
         m_halt = 1'b1; m_fault = 2'b10; m_fpc = m_pc;
         check_status("timeout");
         return;
      end
      check("exec.inst", inst, word);
      check("exec.iv",   32'(inst_valid), 32'(legal));
      check("exec.pc",   pc, m_pc);
      check("exec.req",  32'(imem_req), 32'd0);
      if (!legal) begin
         stall = 1'($urandom_range(0, 1));
         step();
         stall = 1'b0;
         m_halt = 1'b1; m_fault = 2'b01; m_fpc = m_pc;
         check_status("illegal");
         return;
      end
      for (int s = 0; s < nstall; s++) begin
         stall = 1'b1; br_taken = 1'($urandom); br_target = $urandom;
         step();
         check("stall.iv",      32'(inst_valid), 32'd1);
         check("stall.inst",    inst, word);
         check("stall.pc",      pc, m_pc);
         check("stall.instret", instret, m_ret);
      end
      stall = 1'b0; br_taken = br; br_target = tgt;
      step();
      br_taken = 1'b0; br_target = 32'h0;
      m_ret = m_ret + 32'd1;
      npc = br ? {tgt[31:1], 1'b0} : m_pc + 32'd4;
      if (npc[1]) begin
         m_halt = 1'b1; m_fault = 2'b11; m_fpc = m_pc;
      end else begin
         m_pc = npc;
      end
      check_status("commit");
   endtask

   task automatic hold_halt(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         imem_ack = 1'($urandom); imem_rdata = 32'h13;
         step();
         check({tag, ".req"},    32'(imem_req), 32'd0);
         check({tag, ".halted"}, 32'(halted), 32'd1);
         check({tag, ".iv"},     32'(inst_valid), 32'd0);
      end
      imem_ack = 1'b0;
   endtask

   initial begin
      logic [6:0]  ops [9];
      logic [31:0] w, t;
      int          d, ns, len;
      logic        b;

      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

      //           rst ack rdata        stall br tgt     | req addr    inst         iv pc      halt fault fpc     ret
      vecs[0]  = '{1, 0, 32'h0,        0, 0, 32'h0,     0, 32'h0,   32'h0,        0, 32'h0,   0, 0, 32'h0,   0};
      vecs[1]  = '{0, 0, 32'h0,        0, 0, 32'h0,     1, 32'h0,   32'h0,        0, 32'h0,   0, 0, 32'h0,   0};
      vecs[2]  = '{0, 1, 32'h13,       0, 0, 32'h0,     0, 32'h0,   32'h13,       1, 32'h0,   0, 0, 32'h0,   0};
      vecs[3]  = '{0, 0, 32'h0,        0, 0, 32'h0,     1, 32'h4,   32'h0,        0, 32'h4,   0, 0, 32'h0,   1};
      vecs[4]  = '{0, 1, 32'h13,       0, 0, 32'h0,     0, 32'h0,   32'h13,       1, 32'h4,   0, 0, 32'h0,   1};
      vecs[5]  = '{0, 0, 32'h0,        0, 0, 32'h0,     1, 32'h8,   32'h0,        0, 32'h8,   0, 0, 32'h0,   2};
      vecs[6]  = '{0, 1, 32'h00100093, 0, 0, 32'h0,     0, 32'h0,   32'h00100093, 1, 32'h8,   0, 0, 32'h0,   2};
      vecs[7]  = '{0, 0, 32'h0,        0, 1, 32'h101,   1, 32'h100, 32'h0,        0, 32'h100, 0, 0, 32'h0,   3};
      vecs[8]  = '{0, 0, 32'h0,        0, 0, 32'h0,     1, 32'h100, 32'h0,        0, 32'h100, 0, 0, 32'h0,   3};
      vecs[9]  = '{0, 1, 32'h463,      0, 0, 32'h0,     0, 32'h0,   32'h463,      1, 32'h100, 0, 0, 32'h0,   3};
      vecs[10] = '{0, 0, 32'h0,        1, 1, 32'h200,   0, 32'h0,   32'h463,      1, 32'h100, 0, 0, 32'h0,   3};
      vecs[11] = '{0, 0, 32'h0,        1, 0, 32'h0,     0, 32'h0,   32'h463,      1, 32'h100, 0, 0, 32'h0,   3};
      vecs[12] = '{0, 0, 32'h0,        0, 1, 32'h102,   0, 32'h0,   32'h0,        0, 32'h100, 1, 3, 32'h100, 4};
      vecs[13] = '{0, 1, 32'h13,       0, 0, 32'h0,     0, 32'h0,   32'h0,        0, 32'h100, 1, 3, 32'h100, 4};

      rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
      stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;

      for (int i = 0; i < 14; i++) begin
         rst        = vecs[i].rst[0];
         imem_ack   = vecs[i].ack[0];
         imem_rdata = vecs[i].rdata;
         stall      = vecs[i].stall[0];
         br_taken   = vecs[i].br[0];
         br_target  = vecs[i].tgt;
         step();
         check($sformatf("v%0d.req", i),     32'(imem_req),   vecs[i].req);
         check($sformatf("v%0d.addr", i),    imem_addr,       vecs[i].addr);
         check($sformatf("v%0d.inst", i),    inst,            vecs[i].inst);
         check($sformatf("v%0d.iv", i),      32'(inst_valid), vecs[i].iv);
         check($sformatf("v%0d.pc", i),      pc,              vecs[i].pc);
         check($sformatf("v%0d.halted", i),  32'(halted),     vecs[i].halt);
         check($sformatf("v%0d.fault", i),   32'(fault_code), vecs[i].fault);
         check($sformatf("v%0d.fpc", i),     fault_pc,        vecs[i].fpc);
         check($sformatf("v%0d.instret", i), instret,         vecs[i].ret);
      end

      // ack held back three cycles: request and address held for four
      do_reset();
      exec_insn(32'h13, 3, 0, 1'b0, 32'h0);
      exec_insn(32'h00500113, 1, 0, 1'b0, 32'h0);

      // three stalled cycles with a pending redirect, then a plain commit
      do_reset();
      exec_insn(32'h002081b3, 0, 3, 1'b0, 32'h0);
      check("stall.after_addr", imem_addr, 32'h4);

      // misaligned redirect at pc 0x8
      do_reset();
      exec_insn(32'h13, 0, 0, 1'b0, 32'h0);
      exec_insn(32'h13, 0, 0, 1'b0, 32'h0);
      exec_insn(32'h00000067, 0, 0, 1'b1, 32'h102);
      check("misalign.fpc", fault_pc, 32'h8);
      hold_halt("misalign.hold", 4);

      // all-zero word at pc 0x10
      do_reset();
      for (int i = 0; i < 4; i++) exec_insn(32'h13, 0, 0, 1'b0, 32'h0);
      exec_insn(32'h0, 0, 0, 1'b0, 32'h0);
      check("illegal.fpc", fault_pc, 32'h10);
      hold_halt("illegal.hold", 5);

      // no ack at all: exactly TIMEOUT fetch cycles, then halt
      do_reset();
      exec_insn(32'h13, 0, 0, 1'b0, 32'h0);
      exec_insn(32'h13, 100, 0, 1'b0, 32'h0);
      check("timeout.fault", 32'(fault_code), 32'd2);

      // pc wraps from 0xFFFF_FFFC to 0
      do_reset();
      exec_insn(32'h0000006f, 0, 0, 1'b1, 32'hFFFF_FFFD);
      exec_insn(32'h13, 0, 0, 1'b0, 32'h0);
      check("wrap.addr", imem_addr, 32'h0);

      // rst mid-FETCH, then a late ack during IDLE must not start EXEC
      do_reset();
      exec_insn(32'h13, 0, 0, 1'b0, 32'h0);
      step(); step();
      rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h13;
      step();
      check("midrst.pc",      pc, 32'h0);
      check("midrst.req",     32'(imem_req), 32'd0);
      check("midrst.instret", instret, 32'h0);
      rst = 1'b0;
      step();
      imem_ack = 1'b0;
      check("lateack.req",  32'(imem_req), 32'd1);
      check("lateack.addr", imem_addr, 32'h0);
      check("lateack.iv",   32'(inst_valid), 32'd0);
      step();
      check("lateack.req2", 32'(imem_req), 32'd1);

      // randomized programs
      for (int p = 0; p < 40; p++) begin
         do_reset();
         len = $urandom_range(3, 15);
         for (int n = 0; n < len; n++) begin
            w = $urandom;
            if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 8)];
            else w[6:0] = ($urandom_range(0, 1) != 0) ? 7'h00 : 7'h7f;
            if ($urandom_range(0, 59) == 0) d = TIMEOUT + $urandom_range(0, 4);
            else if ($urandom_range(0, 3) == 0) d = $urandom_range(3, TIMEOUT - 1);
            else d = $urandom_range(0, 1);
            ns = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            b  = ($urandom_range(0, 9) < 3);
            t  = {$urandom_range(0, 32'h3fff), 2'b00};
            if ($urandom_range(0, 6) == 0) t[1] = 1'b1;
            t[0] = 1'($urandom);
            exec_insn(w, d, ns, b, t);
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_seq_ctrl.md
Name: fetch_seq_ctrl

Overview:
Multi-cycle fetch/execute sequencer in front of the instruction decoder. It owns the PC and runs a req/ack handshake with instruction memory. It presents one instruction at a time to the decoder and the single-cycle datapath, qualified by inst_valid. It also applies next-PC redirects from branch/JAL/JALR, and halts on illegal opcode, fetch timeout or misaligned target.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
FETCH_TIMEOUT, 16, max FETCH cycles waiting for imem_ack; 0 disables the timeout.

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
imem_req  out  1  fetch request; held high for all of FETCH
imem_addr  out  32  fetch address, equals pc while imem_req=1, else 0
imem_ack  in  1  memory accepts and returns data this cycle; ignored outside FETCH
imem_rdata  in  32  instruction word, valid when imem_ack=1
inst  out  32  instruction to decoder; latched word in EXEC, 32'h0 otherwise (decoder yields all-zero fields)
pc  out  32  address of the current instruction
inst_valid  out  1  high in EXEC for a legal opcode; datapath commits when inst_valid=1 and stall=0
stall  in  1  datapath busy (e.g. data memory); holds EXEC
br_taken  in  1  redirect request, sampled only on the commit cycle
br_target  in  32  redirect target, sampled with br_taken
halted  out  1  sticky; high in HALT
fault_code  out  2  00 none, 01 illegal opcode, 10 fetch timeout, 11 misaligned target
fault_pc  out  32  pc at the moment of the fault
instret  out  32  retired-instruction counter

Behaviour:
- Reset (rst=1 at edge): state=IDLE, pc=RESET_PC, inst reg=0, timeout cnt=0, instret=0, fault_code=00, fault_pc=0. All outputs 0 except pc. rst overrides every state, including mid-FETCH and HALT. An outstanding request is dropped and a late ack after reset is ignored.
- States: IDLE, FETCH, EXEC, HALT.
- IDLE: one cycle, then FETCH.
- FETCH: imem_req=1, imem_addr=pc.
  - imem_ack=1: latch imem_rdata, go to EXEC.
  - No ack: cnt++.
  - No ack, FETCH_TIMEOUT!=0 and cnt==FETCH_TIMEOUT-1: go to HALT, fault 10. An ack in any of the first FETCH_TIMEOUT cycles is accepted.
  - cnt clears on entering FETCH.
- EXEC: inst=latched word.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Legal opcode: inst_valid=1.
  - Illegal opcode (incl. all-zero word): inst_valid=0, next state HALT, fault 01.
  - stall=1: stay in EXEC, all outputs held; br_taken/br_target ignored.
  - stall=0 (commit): instret++ (wraps at 2^32), compute next_pc, go to FETCH.
- next_pc:
  - br_taken=0: pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - br_taken=1: {br_target[31:1],1'b0}, i.e. bit0 cleared (JALR rule).
  - If next_pc[1]=1: go to HALT, fault 11, fault_pc=current pc; pc is not updated and instret still increments.
- HALT: imem_req=0, inst_valid=0, inst=0, halted=1; stays until rst. fault_code and fault_pc hold.
- Throughput: minimum 2 cycles per instruction (FETCH with same-cycle ack, then EXEC). Each stalled cycle or extra ack-wait cycle adds one.
- Simultaneous events: stall=1 with br_taken=1 means the redirect is not applied until the commit cycle; the datapath must hold br_* valid. imem_ack in EXEC/IDLE/HALT has no effect.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC), for reuse by the decoder and other control.
  - state enum: IDLE/FETCH/EXEC/HALT.
  - fault_code enum.
  - function is_legal_opcode().
- No sub-module: the FSM, PC register, timeout counter and instret counter live in one module.

Test Plan:
- Reset then release, memory acks at once with 32'h00000013 at 0,4,8 -> imem_addr 0,4,8; inst_valid every 2nd cycle; instret=3 after 6 cycles.
- Ack delayed 3 cycles -> imem_req held 4 cycles with addr steady; inst latched on the ack cycle; inst_valid 1 cycle later.
- Commit at pc=0x8 with br_taken=1, br_target=0x101 -> next imem_addr=0x100. br_target=0x102 -> HALT, fault_code=11, fault_pc=0x8.
- stall=1 for 3 cycles in EXEC -> inst_valid stays high 4 cycles, pc unchanged, instret increments once.
- Fetched word 32'h00000000 at pc=0x10 -> inst_valid never high, halted=1, fault_code=01, fault_pc=0x10; no further imem_req until rst.
- FETCH_TIMEOUT=16, no ack -> HALT after exactly 16 FETCH cycles, fault_code=10. Assert rst mid-FETCH -> pc=RESET_PC, imem_req=0 next cycle.
